// File: rtl/agu_vgrp.sv
`default_nettype none
// ============================================================================
//  Module      : agu_vgrp
//  Description : Vector register-file address generation unit. Turns one
//                vector-operand request (base register, VL, SEW) into a
//                valid/ready stream of VRF row addresses with per-row byte
//                enables. Supports LMUL group spill, widening operands,
//                optional per-byte masking and two-pass address repeat.
//                Optional macro AGU_VGRP_SCALAR_EN adds the s_value input
//                (reduction scalar operand: every beat hits the base row).
//  Revision    : 1.0 - initial release
// ============================================================================
module agu_vgrp #(
   parameter int DATA_BYTES    = 8,
   parameter int ROWS_PER_VREG = 4,
   parameter int ADDR_WIDTH    = 8,
   parameter int VL_WIDTH      = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [4:0]            vr_in,
   input  logic [VL_WIDTH-1:0]   vl_in,
   input  logic [2:0]            vsew,
   input  logic                  wide,
   input  logic                  masked,
   input  logic                  repeat_addr,
`ifdef AGU_VGRP_SCALAR_EN
   input  logic                  s_value,
`endif
   input  logic [DATA_BYTES-1:0] mask_in,
   output logic                  addr_valid,
   input  logic                  addr_ready,
   output logic [ADDR_WIDTH-1:0] addr_out,
   output logic [ADDR_WIDTH-1:0] addr_mask,
   output logic [DATA_BYTES-1:0] b_en,
   output logic                  start_v,
   output logic                  end_v
);

   localparam int c_LOG_DB  = $clog2(DATA_BYTES);
   localparam int c_LOG_RPV = $clog2(ROWS_PER_VREG);
   localparam logic [2:0] c_LOG_DB_3 = 3'(c_LOG_DB);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_k_inc;
   logic                  w_accept;

   logic [ADDR_WIDTH-1:0] r_base;
   logic [VL_WIDTH-1:0]   r_k;
   logic [VL_WIDTH-1:0]   r_nbeats;
   logic [DATA_BYTES-1:0] r_last_ben;
   logic                  r_masked;
   logic                  r_repeat;
   logic                  r_scalar;
   logic                  w_scalar_req;

   logic [1:0]            w_sew_lg;
   logic [2:0]            w_eew_lg;
   logic [2:0]            w_epr_lg;
   logic [VL_WIDTH:0]     w_vl_ext;
   logic [VL_WIDTH:0]     w_epr_m1;
   logic [VL_WIDTH-1:0]   w_nbeats;
   logic [31:0]           w_rem;
   logic [31:0]           w_rem_bytes;
   logic [DATA_BYTES-1:0] w_last_ben;
   logic [ADDR_WIDTH-1:0] w_base;
   logic [ADDR_WIDTH-1:0] w_k_addr;
   logic                  w_last;
   logic [DATA_BYTES-1:0] w_ben_raw;

`ifdef AGU_VGRP_SCALAR_EN
   assign w_scalar_req = s_value;
`else
   assign w_scalar_req = 1'b0;
`endif

   // Element geometry of the incoming request: log2 EEW, log2 EPR, beat count
   // and the partial byte-enable pattern for the final row.
   always_comb begin
      // Reserved SEW codes above 3 are treated as 64-bit elements.
      w_sew_lg = (vsew > 3'd3) ? 2'd3 : vsew[1:0];
      // Widening a 64-bit SEW is illegal and is treated as an 8-byte EEW.
      if (w_sew_lg == 2'd3) w_eew_lg = 3'd3;
      else                  w_eew_lg = {1'b0, w_sew_lg} + {2'b00, wide};
      if (w_eew_lg > c_LOG_DB_3) w_eew_lg = c_LOG_DB_3;
      w_epr_lg    = c_LOG_DB_3 - w_eew_lg;
      w_vl_ext    = {1'b0, vl_in};
      w_epr_m1    = ~({(VL_WIDTH+1){1'b1}} << w_epr_lg);
      w_nbeats    = VL_WIDTH'((w_vl_ext + w_epr_m1) >> w_epr_lg);
      w_rem       = 32'(w_vl_ext & w_epr_m1);
      w_rem_bytes = w_rem << w_eew_lg;
      if (w_rem == 32'd0) w_last_ben = {DATA_BYTES{1'b1}};
      else                w_last_ben = ~({DATA_BYTES{1'b1}} << w_rem_bytes);
   end

   assign w_base = ADDR_WIDTH'(vr_in) << c_LOG_RPV;

   // Beat index folded into the row-address width (modulo 2^ADDR_WIDTH).
   generate
      if (VL_WIDTH >= ADDR_WIDTH) begin : g_kaddr_trunc
         assign w_k_addr = r_k[ADDR_WIDTH-1:0];
      end else begin : g_kaddr_ext
         assign w_k_addr = {{(ADDR_WIDTH-VL_WIDTH){1'b0}}, r_k};
      end
   endgenerate

   assign w_last   = (r_k == r_nbeats - VL_WIDTH'(1));
   assign w_accept = (r_state == S_IDLE) && req_valid;

   // State register and request capture; counters clear on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_base     <= '0;
         r_k        <= '0;
         r_nbeats   <= '0;
         r_last_ben <= '0;
         r_masked   <= 1'b0;
         r_repeat   <= 1'b0;
         r_scalar   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_base     <= w_base;
            r_k        <= '0;
            r_nbeats   <= w_nbeats;
            r_last_ben <= w_last_ben;
            r_masked   <= masked;
            r_repeat   <= repeat_addr;
            r_scalar   <= w_scalar_req;
         end else if (w_k_inc) begin
            r_k <= r_k + VL_WIDTH'(1);
         end
      end
   end

   // Next-state and handshake/marker outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_k_inc     = 1'b0;
      req_ready   = 1'b0;
      addr_valid  = 1'b0;
      start_v     = 1'b0;
      end_v       = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid && (vl_in != '0)) w_state_nxt = S_RUN;
         end
         S_RUN: begin
            addr_valid = 1'b1;
            start_v    = (r_k == '0);
            end_v      = w_last && !r_repeat;
            if (addr_ready) begin
               if (r_repeat)    w_state_nxt = S_HOLD;
               else if (w_last) w_state_nxt = S_DONE;
               else             w_k_inc     = 1'b1;
            end
         end
         S_HOLD: begin
            addr_valid = 1'b1;
            end_v      = w_last;
            if (addr_ready) begin
               if (w_last) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_k_inc     = 1'b1;
                  w_state_nxt = S_RUN;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Beat data: row address, mask-row index and byte enables, zero when idle.
   always_comb begin
      w_ben_raw = w_last ? r_last_ben : {DATA_BYTES{1'b1}};
      if (r_masked) w_ben_raw = w_ben_raw & mask_in;
      addr_out  = '0;
      addr_mask = '0;
      b_en      = '0;
      if (addr_valid) begin
         addr_out  = r_base + (r_scalar ? {ADDR_WIDTH{1'b0}} : w_k_addr);
         addr_mask = r_masked ? w_k_addr : {ADDR_WIDTH{1'b0}};
         b_en      = w_ben_raw;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_agu_vgrp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agu_vgrp
//  Description : Directed, table-driven bench for agu_vgrp (DATA_BYTES=8,
//                ROWS_PER_VREG=4) plus hand-written multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agu_vgrp;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [4:0] vr_in;
   logic [9:0] vl_in;
   logic [2:0] vsew;
   logic       wide;
   logic       masked;
   logic       repeat_addr;
`ifdef AGU_VGRP_SCALAR_EN
   logic       s_value;
`endif
   logic [7:0] mask_in;
   logic       addr_valid;
   logic       addr_ready;
   logic [7:0] addr_out;
   logic [7:0] addr_mask;
   logic [7:0] b_en;
   logic       start_v;
   logic       end_v;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   agu_vgrp #(
      .DATA_BYTES(8), .ROWS_PER_VREG(4), .ADDR_WIDTH(8), .VL_WIDTH(10)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .vr_in(vr_in), .vl_in(vl_in), .vsew(vsew), .wide(wide),
      .masked(masked), .repeat_addr(repeat_addr),
`ifdef AGU_VGRP_SCALAR_EN
      .s_value(s_value),
`endif
      .mask_in(mask_in),
      .addr_valid(addr_valid), .addr_ready(addr_ready),
      .addr_out(addr_out), .addr_mask(addr_mask), .b_en(b_en),
      .start_v(start_v), .end_v(end_v)
   );

   // One request and its expected beat stream; byte i of addr/ben is issue i.
   typedef struct {
      logic [4:0]  vr;
      logic [9:0]  vl;
      logic [2:0]  sew;
      logic        wide;
      logic        masked;
      logic        rep;
      logic [7:0]  mask;
      int          n;
      logic [63:0] addr;
      logic [63:0] ben;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, then scramble the request inputs to show they are
   // only sampled at acceptance, and check every beat plus the DONE gap.
   task automatic run_vec(input vec_t v);
      int beat;
      chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
      vr_in = v.vr; vl_in = v.vl; vsew = v.sew; wide = v.wide;
      masked = v.masked; repeat_addr = v.rep; mask_in = v.mask;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      vr_in = ~v.vr; vl_in = 10'd0; vsew = 3'd0; wide = ~v.wide;
      masked = ~v.masked; repeat_addr = ~v.rep;
      for (int i = 0; i < v.n; i++) begin
         beat = v.rep ? i / 2 : i;
         chk("addr_valid", {63'd0, addr_valid}, 64'd1);
         chk("addr_out", {56'd0, addr_out}, {56'd0, v.addr[i*8 +: 8]});
         chk("b_en", {56'd0, b_en}, {56'd0, v.ben[i*8 +: 8]});
         chk("start_v", {63'd0, start_v}, {63'd0, i == 0});
         chk("end_v", {63'd0, end_v}, {63'd0, i == v.n - 1});
         chk("addr_mask", {56'd0, addr_mask}, v.masked ? 64'(beat) : 64'd0);
         tick();
      end
      chk("done_valid", {63'd0, addr_valid}, 64'd0);
      chk("done_ready", {63'd0, req_ready}, 64'd0);
      tick();
      chk("idle_ready", {63'd0, req_ready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t v;
      //          vr     vl     sew  wide  msk   rep   mask  n  addr                  ben
      tbl[0] = '{5'd3,  10'd5, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00, 3, 64'h0E0D0C,        64'h0FFFFF};
      tbl[1] = '{5'd2,  10'd6, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 3, 64'h0A0908,        64'hFFFFFF};
      tbl[2] = '{5'd2,  10'd7, 3'd1, 1'b1, 1'b0, 1'b0, 8'h00, 4, 64'h0B0A0908,      64'h0FFFFFFF};
      tbl[3] = '{5'd1,  10'd3, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 6, 64'h060605050404,  64'hFFFFFFFFFFFF};
      tbl[4] = '{5'd7,  10'd2, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 2, 64'h1D1C,          64'hFFFF};
      tbl[5] = '{5'd4,  10'd3, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1, 64'h10,            64'h07};
      tbl[6] = '{5'd0,  10'd3, 3'd2, 1'b0, 1'b1, 1'b0, 8'h3C, 2, 64'h0100,          64'h0C3C};
      tbl[7] = '{5'd31, 10'd3, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 3, 64'h7E7D7C,        64'hFFFFFF};
      tbl[8] = '{5'd6,  10'd9, 3'd0, 1'b0, 1'b1, 1'b1, 8'h5A, 4, 64'h19191818,      64'h00005A5A};
      tbl[9] = '{5'd9,  10'd4, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 64'h24,            64'hFF};

      rst = 1'b1; req_valid = 1'b0; vr_in = '0; vl_in = '0; vsew = '0;
      wide = 1'b0; masked = 1'b0; repeat_addr = 1'b0; mask_in = '0;
      addr_ready = 1'b1;
`ifdef AGU_VGRP_SCALAR_EN
      s_value = 1'b0;
`endif
      repeat (3) tick();
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_addr_valid", {63'd0, addr_valid}, 64'd0);
      chk("rst_addr_out", {56'd0, addr_out}, 64'd0);
      chk("rst_b_en", {56'd0, b_en}, 64'd0);
      chk("rst_start_end", {62'd0, start_v, end_v}, 64'd0);
      chk("rst_addr_mask", {56'd0, addr_mask}, 64'd0);
      rst = 1'b0;
      tick();

      for (int t = 0; t < 10; t++) run_vec(tbl[t]);

      // Backpressure: single masked beat held for three cycles.
      vr_in = 5'd0; vl_in = 10'd8; vsew = 3'd0; wide = 1'b0; masked = 1'b1;
      repeat_addr = 1'b0; mask_in = 8'hA5; addr_ready = 1'b0; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("bp_valid", {63'd0, addr_valid}, 64'd1);
         chk("bp_addr", {56'd0, addr_out}, 64'd0);
         chk("bp_b_en", {56'd0, b_en}, 64'hA5);
         chk("bp_start_end", {62'd0, start_v, end_v}, 64'd3);
         chk("bp_addr_mask", {56'd0, addr_mask}, 64'd0);
         tick();
      end
      addr_ready = 1'b1;
      chk("bp_4th_valid", {63'd0, addr_valid}, 64'd1);
      chk("bp_4th_b_en", {56'd0, b_en}, 64'hA5);
      tick();
      chk("bp_done_valid", {63'd0, addr_valid}, 64'd0);
      tick();
      chk("bp_idle_ready", {63'd0, req_ready}, 64'd1);
      masked = 1'b0;

      // vl=0: accepted, no beats, stays idle.
      vl_in = 10'd0; vr_in = 5'd3; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("vl0_valid", {63'd0, addr_valid}, 64'd0);
      chk("vl0_ready", {63'd0, req_ready}, 64'd1);
      tick();
      chk("vl0_valid2", {63'd0, addr_valid}, 64'd0);

      // Reset during beat 1 of a 4-beat stream, then a fresh request.
      vr_in = 5'd3; vl_in = 10'd4; vsew = 3'd3; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("rs_beat0", {56'd0, addr_out}, 64'd12);
      tick();
      chk("rs_beat1", {56'd0, addr_out}, 64'd13);
      chk("rs_beat1_start", {63'd0, start_v}, 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_valid", {63'd0, addr_valid}, 64'd0);
      chk("rs_ready", {63'd0, req_ready}, 64'd1);
      chk("rs_addr", {56'd0, addr_out}, 64'd0);
      v = '{5'd3, 10'd1, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00, 1, 64'h0C, 64'hFF};
      run_vec(v);

`ifdef AGU_VGRP_SCALAR_EN
      // Reduction scalar operand: every beat hits the base row.
      s_value = 1'b1;
      v = '{5'd5, 10'd4, 3'd2, 1'b0, 1'b0, 1'b0, 8'h00, 2, 64'h1414, 64'hFFFF};
      run_vec(v);
      s_value = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/agu_vgrp.md
Name: agu_vgrp

Overview:
- Parametrised vector-register-file address generation unit, successor to the fixed-width AGU.
- Converts one vector-operand request (base register, VL, SEW) into a stream of row addresses with per-row byte enables.
- Adds a configurable row width, register depth and LMUL register-group spill.
- Adds a widening-operand mode (EEW = 2*SEW) and a proper valid/ready address stream with backpressure.
- Sits between the vector decode/issue stage and the VRF read/write ports. One instance per operand port.

Parameters:
- DATA_BYTES, 8: bytes per VRF row; power of 2, range 4..64.
- ROWS_PER_VREG, 4: VRF rows per architectural vector register; power of 2.
- ADDR_WIDTH, 8: row address width.
- VL_WIDTH, 10: width of the vector length input.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- req_valid  in  1  operand request valid
- req_ready  out  1  AGU idle, request accepted this cycle when req_valid is also high
- vr_in  in  5  base vector register
- vl_in  in  VL_WIDTH  element count
- vsew  in  3  SEW code: 0=8b, 1=16b, 2=32b, 3=64b
- wide  in  1  operand EEW is 2*SEW
- masked  in  1  apply mask_in to byte enables
- repeat_addr  in  1  issue every address twice (two-pass operations)
- mask_in  in  DATA_BYTES  per-byte mask for the current beat (from the mask unit)
- addr_valid  out  1  addr_out/b_en valid
- addr_ready  in  1  consumer accepts the beat
- addr_out  out  ADDR_WIDTH  VRF row address
- addr_mask  out  ADDR_WIDTH  mask-row index: beat index when masked, else 0
- b_en  out  DATA_BYTES  byte enables
- start_v  out  1  first beat of the operand
- end_v  out  1  last beat of the operand

Behaviour:
- Reset values: all outputs 0, except req_ready=1. Reset mid-operation aborts the stream, state returns to IDLE, counters clear.
- Request inputs are sampled only on acceptance; later changes have no effect.
- Effective element width:
  - EEW_B = (1<<vsew) bytes, doubled when wide=1.
  - vsew=3 with wide=1 is illegal; treat it as EEW_B=8.
  - EEW_B > DATA_BYTES is clamped to DATA_BYTES.
- Elements per row: EPR = DATA_BYTES/EEW_B.
- Beat count: NBEATS = ceil(vl/EPR), computed at acceptance with shifts (no divider).
- Beat k (0-based):
  - addr_out = vr_in*ROWS_PER_VREG + k, modulo 2^ADDR_WIDTH.
  - k may exceed ROWS_PER_VREG; this is register-group spill into vr+1, vr+2, …, with no clamp.
- Byte enables:
  - Full beats: all ones.
  - Last beat with rem = vl - (NBEATS-1)*EPR < EPR: low rem*EEW_B bits set.
  - masked=1: AND the result with mask_in, sampled in the same cycle the beat is presented.
- States:
  - IDLE: req_ready=1. On req_valid, accept; vl=0 stays in IDLE with no beats; otherwise go to RUN.
  - RUN: addr_valid=1 and beat k presented. On addr_ready:
    - repeat_addr=1 → HOLD.
    - else last beat → DONE.
    - else k+1, stay in RUN.
  - HOLD: re-present the same beat (same addr and b_en; mask_in is resampled). On addr_ready: last beat → DONE, else k+1 → RUN.
  - DONE: single cycle; addr_valid=0, req_ready goes high → IDLE.
- Latency and throughput:
  - First beat is valid the cycle after acceptance.
  - One beat per cycle when addr_ready is held high.
  - Back-to-back requests have a minimum gap of 2 cycles (DONE plus IDLE accept).
- Backpressure: while addr_valid=1 and addr_ready=0, addr_out, b_en, addr_mask, start_v and end_v hold stable.
- start_v is high with beat 0, first issue only.
- end_v is high with the last beat, final issue only.
- When NBEATS=1 and there is no repeat, start_v and end_v are high together.
- Beat counter width is VL_WIDTH; it never wraps because NBEATS ≤ vl.

Optional Feature:
- Macro AGU_VGRP_SCALAR_EN.
- Defined:
  - Adds input s_value (1b), sampled at acceptance.
  - When s_value=1, every beat's addr_out = vr_in*ROWS_PER_VREG (reduction scalar operand). Beat count, b_en, start_v and end_v are unchanged.
- Undefined: the port is absent and addresses always increment.

Test Plan (DATA_BYTES=8, ROWS_PER_VREG=4):
1. vr=3, vsew=2, vl=5, unmasked, addr_ready=1 → addr 12,13,14; b_en FF,FF,0F; start_v on beat 0, end_v on beat 2; req_ready high 2 cycles after the last beat.
2. vr=2, vsew=1, wide=1, vl=6 → EPR=2, addr 8,9,10; b_en FF,FF,FF. With vl=7 → 4 beats, last b_en 0F, addr 11 (spill into v2 group end).
3. vr=1, vsew=3, vl=3, repeat_addr=1 → addr 4,4,5,5,6,6; start_v only on the first 4, end_v only on the second 6.
4. vsew=0, vl=8, masked, mask_in=A5 → one beat, b_en=A5, addr_mask=0. Hold addr_ready=0 for 3 cycles → outputs stable; accepted on the 4th cycle.
5. vl=0 → no addr_valid, req_ready remains high. Assert rst during beat 1 of a 4-beat stream → next cycle addr_valid=0, req_ready=1; a fresh request restarts at beat 0.
6. With AGU_VGRP_SCALAR_EN, s_value=1, vr=5, vsew=2, vl=4 → addr 20,20; b_en FF,FF.
